mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between two masters: M0, the processor control unit/datapath (instruction fetch, lw/sw, push/pop), and M1, a secondary master (program loader / debug / DMA).
- Sits between the masters and the memory model. Drives the memory READ/WRITE strobes, address and write data, and returns read data and a completion pulse to the granted master.
- Applies round-robin arbitration and inserts a programmable number of memory wait cycles per access.

Parameters:
DATA_WIDTH, 32, width of data buses
ADDR_WIDTH, 26, width of address buses
MEM_LATENCY, 2, cycles MEM_READ/MEM_WRITE are held per access (legal range 1..15)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset, asynchronous, active-low
M0_REQ  input  1  M0 access request; held high until M0_DONE
M0_WE  input  1  M0 access type: 1 = write, 0 = read
M0_ADDR  input  ADDR_WIDTH  M0 address
M0_WDATA  input  DATA_WIDTH  M0 write data
M0_GNT  output  1  M0 owns memory port
M0_DONE  output  1  one-cycle M0 completion pulse
M1_REQ, M1_WE, M1_ADDR, M1_WDATA  input  1/1/ADDR_WIDTH/DATA_WIDTH  same as M0 signals, for M1
M1_GNT, M1_DONE  output  1  same as M0 signals, for M1
RDATA  output  DATA_WIDTH  captured read data; valid in the DONE cycle
MEM_READ  output  1  memory read strobe
MEM_WRITE  output  1  memory write strobe
MEM_ADDR  output  ADDR_WIDTH  memory address
MEM_WDATA  output  DATA_WIDTH  memory write data
MEM_RDATA  input  DATA_WIDTH  memory read data
BUSY  output  1  high whenever state is not IDLE

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE, last_owner = M1 (so M0 wins the first tie), wait counter = 0.
  - All outputs are 0, including RDATA, MEM_ADDR and MEM_WDATA.
  - Any access in progress is aborted silently; no DONE is issued and the masters must re-request.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled at the rising edge.
  - If exactly one REQ is high, that master is selected.
  - If both are high, the master that is not last_owner is selected.
  - The selected master's WE, ADDR and WDATA are latched into internal registers. Master inputs are ignored after this point until the next IDLE.
  - last_owner is updated, the counter is loaded with MEM_LATENCY-1, and the FSM goes to ACCESS.
  - If no REQ is high, the FSM stays in IDLE.
- ACCESS:
  - MEM_ADDR/MEM_WDATA are driven from the latched registers.
  - MEM_WRITE equals latched WE; MEM_READ equals NOT latched WE. They are never both high.
  - The owner's GNT is high.
  - The counter decrements each cycle. On the edge where the counter is 0:
    - RDATA <= MEM_RDATA, for reads only; for writes RDATA is held unchanged.
    - The FSM goes to DONE.
- DONE (exactly one cycle):
  - MEM_READ = MEM_WRITE = 0. MEM_ADDR and MEM_WDATA hold their values.
  - The owner's GNT stays high and the owner's DONE is high.
  - The FSM goes to IDLE unconditionally.
  - A REQ still high during DONE is treated as a new request, sampled in IDLE on the following edge.
- Timing:
  - A request first sampled at edge k gives ACCESS in cycles k+1 .. k+MEM_LATENCY and DONE in cycle k+MEM_LATENCY+1.
  - Back-to-back accesses have one IDLE cycle between DONE and the next ACCESS.
- REQ deasserted during ACCESS does not abort the access; it completes and DONE is still pulsed.
- GNT: at most one GNT is high. GNT is 0 in IDLE.
- Fairness: with both REQ held continuously, ownership strictly alternates M0, M1, M0, ...
- RDATA holds its last value until the next read completes.
- Outputs are registered or decoded from registered state only; there are no combinational paths from REQ to MEM_* signals.

Test Plan:
1. Single read, MEM_LATENCY=2:
   - Stimulus: M0_REQ=1, M0_WE=0, M0_ADDR=0x0001000; memory returns 0xDEADBEEF.
   - Required: MEM_READ high for exactly 2 cycles with MEM_ADDR=0x0001000; M0_DONE pulses 3 cycles after the request edge with RDATA=0xDEADBEEF; M1_GNT stays 0.
2. Single write from M1:
   - Stimulus: M1_WE=1, M1_ADDR=0x03FFFFF, M1_WDATA=0x12345678.
   - Required: MEM_WRITE high 2 cycles with those address/data values; MEM_READ stays 0; M1_DONE pulses once; RDATA unchanged.
3. Simultaneous requests, both held for 4 accesses:
   - Required: grant order is M0, M1, M0, M1; each DONE is followed by exactly one IDLE cycle; GNT is never high for both masters.
4. Reset mid-access:
   - Stimulus: drop RST in the 1st ACCESS cycle of an M0 read.
   - Required: MEM_READ, GNT and BUSY go to 0 immediately; no M0_DONE is issued.
   - After release, with both requesting, M0 is granted first.
5. Request withdrawn:
   - Stimulus: M0 drops REQ in cycle 1 of ACCESS.
   - Required: the access still completes and M0_DONE pulses once; no second grant follows.
6. MEM_LATENCY=1 build:
   - Required: MEM_READ high for exactly 1 cycle; DONE occurs 2 cycles after the request edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single memory port.
// Each access holds the memory strobe for MEM_LATENCY cycles and then pulses DONE to the owner.
module mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 26,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  M0_REQ,
    input  logic                  M0_WE,
    input  logic [ADDR_WIDTH-1:0] M0_ADDR,
    input  logic [DATA_WIDTH-1:0] M0_WDATA,
    output logic                  M0_GNT,
    output logic                  M0_DONE,

    input  logic                  M1_REQ,
    input  logic                  M1_WE,
    input  logic [ADDR_WIDTH-1:0] M1_ADDR,
    input  logic [DATA_WIDTH-1:0] M1_WDATA,
    output logic                  M1_GNT,
    output logic                  M1_DONE,

    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                state;
    state_t                next_state;
    logic                  owner;
    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [3:0]            cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  sel_any;
    logic                  sel_m1;

    // owner doubles as last_owner: it keeps the previous winner until the next grant.
    // On a tie the master that did not win last time is picked.
    always_comb begin
        sel_any = M0_REQ | M1_REQ;
        sel_m1  = M1_REQ & (~M0_REQ | ~owner);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        BUSY       = 1'b0;
        MEM_READ   = 1'b0;
        MEM_WRITE  = 1'b0;
        M0_GNT     = 1'b0;
        M1_GNT     = 1'b0;
        M0_DONE    = 1'b0;
        M1_DONE    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                BUSY      = 1'b1;
                MEM_READ  = ~lat_we;
                MEM_WRITE = lat_we;
                M0_GNT    = ~owner;
                M1_GNT    = owner;
                if (cnt == 4'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                BUSY       = 1'b1;
                M0_GNT     = ~owner;
                M1_GNT     = owner;
                M0_DONE    = ~owner;
                M1_DONE    = owner;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Master inputs are only looked at in IDLE; afterwards the latched copy drives the port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner     <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= 4'd0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        owner     <= sel_m1;
                        lat_we    <= sel_m1 ? M1_WE    : M0_WE;
                        lat_addr  <= sel_m1 ? M1_ADDR  : M0_ADDR;
                        lat_wdata <= sel_m1 ? M1_WDATA : M0_WDATA;
                        cnt       <= CNT_LOAD;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            rdata_q <= MEM_RDATA;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign MEM_ADDR  = lat_addr;
    assign MEM_WDATA = lat_wdata;
    assign RDATA     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: tasks push expected accesses, a negedge monitor pops them on DONE.
// A second instance built with MEM_LATENCY=1 covers the shortest access.
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int LAT = 2;

    typedef struct {
        logic          owner;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          M0_REQ = 1'b0, M0_WE = 1'b0;
    logic [AW-1:0] M0_ADDR = '0;
    logic [DW-1:0] M0_WDATA = '0;
    logic          M1_REQ = 1'b0, M1_WE = 1'b0;
    logic [AW-1:0] M1_ADDR = '0;
    logic [DW-1:0] M1_WDATA = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          M0_GNT, M0_DONE, M1_GNT, M1_DONE;
    logic [DW-1:0] RDATA, MEM_WDATA;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_READ, MEM_WRITE, BUSY;

    logic          l1_m0_req = 1'b0, l1_m0_we = 1'b0, l1_m1_req = 1'b0, l1_m1_we = 1'b0;
    logic [AW-1:0] l1_m0_addr = '0, l1_m1_addr = '0;
    logic [DW-1:0] l1_m0_wdata = '0, l1_m1_wdata = '0;
    logic          l1_m0_gnt, l1_m0_done, l1_m1_gnt, l1_m1_done;
    logic [DW-1:0] l1_rdata, l1_mem_wdata;
    logic [AW-1:0] l1_mem_addr;
    logic          l1_mem_read, l1_mem_write, l1_busy;

    int            checks = 0;
    int            errors = 0;
    exp_t          sb[$];
    logic [DW-1:0] model_rdata = '0;
    int            acc_cnt = 0;
    exp_t          mon_e;

    always #5 CLK = ~CLK;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_GNT(M0_GNT), .M0_DONE(M0_DONE),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_GNT(M1_GNT), .M1_DONE(M1_DONE),
        .RDATA(RDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(mem_rdata), .BUSY(BUSY)
    );

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .M0_REQ(l1_m0_req), .M0_WE(l1_m0_we), .M0_ADDR(l1_m0_addr), .M0_WDATA(l1_m0_wdata),
        .M0_GNT(l1_m0_gnt), .M0_DONE(l1_m0_done),
        .M1_REQ(l1_m1_req), .M1_WE(l1_m1_we), .M1_ADDR(l1_m1_addr), .M1_WDATA(l1_m1_wdata),
        .M1_GNT(l1_m1_gnt), .M1_DONE(l1_m1_done),
        .RDATA(l1_rdata), .MEM_READ(l1_mem_read), .MEM_WRITE(l1_mem_write),
        .MEM_ADDR(l1_mem_addr), .MEM_WDATA(l1_mem_wdata), .MEM_RDATA(mem_rdata), .BUSY(l1_busy)
    );

    task automatic push_exp(input logic owner, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rd);
        exp_t e;
        if (!we) model_rdata = rd;
        e.owner = owner;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = model_rdata;
        sb.push_back(e);
    endtask

    // Monitor: every strobe cycle must match the head of the scoreboard; DONE pops it.
    always @(negedge CLK) begin
        if (!RST) begin
            acc_cnt = 0;
        end else begin
            checks++;
            if ((M0_GNT && M1_GNT) || (MEM_READ && MEM_WRITE) || (!BUSY && (M0_GNT || M1_GNT))) begin
                errors++;
                $display("[TB] FAIL exclusive: gnt=%b%b rd=%b wr=%b busy=%b, required one gnt only when busy and never rd+wr",
                         M0_GNT, M1_GNT, MEM_READ, MEM_WRITE, BUSY);
            end
            if (MEM_READ || MEM_WRITE) begin
                acc_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_access: addr=%h we=%b, required no access", MEM_ADDR, MEM_WRITE);
                end else begin
                    mon_e = sb[0];
                    if (MEM_ADDR !== mon_e.addr || MEM_WRITE !== mon_e.we || MEM_READ !== !mon_e.we ||
                        (mon_e.we && MEM_WDATA !== mon_e.wdata) || M1_GNT !== mon_e.owner || M0_GNT !== !mon_e.owner) begin
                        errors++;
                        $display("[TB] FAIL access: addr=%h wr=%b wdata=%h gnt=%b%b, required addr=%h wr=%b wdata=%h owner=%0d",
                                 MEM_ADDR, MEM_WRITE, MEM_WDATA, M0_GNT, M1_GNT, mon_e.addr, mon_e.we, mon_e.wdata, mon_e.owner);
                    end
                end
            end
            if (M0_DONE || M1_DONE) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_done: done=%b%b, required no done", M0_DONE, M1_DONE);
                end else begin
                    mon_e = sb.pop_front();
                    if ({M1_DONE, M0_DONE} !== {mon_e.owner, ~mon_e.owner} || RDATA !== mon_e.rdata || acc_cnt != LAT) begin
                        errors++;
                        $display("[TB] FAIL completion: done=%b%b rdata=%h strobe_cycles=%0d, required owner=%0d rdata=%h strobe_cycles=%0d",
                                 M0_DONE, M1_DONE, RDATA, acc_cnt, mon_e.owner, mon_e.rdata, LAT);
                    end
                end
                acc_cnt = 0;
            end
        end
    end

    task automatic test_reset();
        logic [2*DW+AW+8:0] outs;
        repeat (3) @(negedge CLK);
        outs = {M0_GNT, M0_DONE, M1_GNT, M1_DONE, RDATA, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, BUSY, l1_busy};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, required all zero", outs);
        end
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || M0_GNT !== 1'b0 || M1_GNT !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b gnt=%b%b, required 0 00", BUSY, M0_GNT, M1_GNT);
        end
    endtask

    task automatic test_single_read();
        int          rd_cycles = 0;
        int          done_cyc = -1;
        int          done_cnt = 0;
        bit          m1_gnt_seen = 1'b0;
        bit          addr_bad = 1'b0;
        logic [DW-1:0] rd_at_done = '0;
        @(negedge CLK);
        M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 26'h0001000; mem_rdata = 32'hDEADBEEF;
        push_exp(1'b0, 1'b0, 26'h0001000, '0, 32'hDEADBEEF);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge CLK);
            if (MEM_READ) begin
                rd_cycles++;
                if (MEM_ADDR !== 26'h0001000) addr_bad = 1'b1;
            end
            if (M1_GNT) m1_gnt_seen = 1'b1;
            if (M0_DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                rd_at_done = RDATA;
                M0_REQ = 1'b0;
            end
        end
        checks++;
        if (rd_cycles != 2 || addr_bad) begin
            errors++;
            $display("[TB] FAIL read_strobe: cycles=%0d addr_bad=%0d, required 2 0", rd_cycles, addr_bad);
        end
        checks++;
        if (done_cyc != 3 || done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL read_done_timing: cycle=%0d count=%0d, required 3 1", done_cyc, done_cnt);
        end
        checks++;
        if (rd_at_done !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL read_data: got %h, required deadbeef", rd_at_done);
        end
        checks++;
        if (m1_gnt_seen) begin
            errors++;
            $display("[TB] FAIL read_m1_gnt: got 1, required 0");
        end
    endtask

    task automatic test_single_write();
        int wr_cycles = 0;
        int done_cnt = 0;
        bit rd_seen = 1'b0;
        @(negedge CLK);
        M1_REQ = 1'b1; M1_WE = 1'b1; M1_ADDR = 26'h03FFFFF; M1_WDATA = 32'h12345678;
        mem_rdata = 32'hA5A5A5A5;
        push_exp(1'b1, 1'b1, 26'h03FFFFF, 32'h12345678, '0);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge CLK);
            if (MEM_WRITE && MEM_ADDR === 26'h03FFFFF && MEM_WDATA === 32'h12345678) wr_cycles++;
            if (MEM_READ) rd_seen = 1'b1;
            if (M1_DONE) begin
                done_cnt++;
                M1_REQ = 1'b0;
            end
        end
        checks++;
        if (wr_cycles != 2 || rd_seen) begin
            errors++;
            $display("[TB] FAIL write_strobe: cycles=%0d read_seen=%0d, required 2 0", wr_cycles, rd_seen);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL write_done: count=%0d, required 1", done_cnt);
        end
        checks++;
        if (RDATA !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_rdata_held: got %h, required deadbeef", RDATA);
        end
    endtask

    task automatic test_back_to_back();
        int order[4];
        int ndone = 0;
        int idle_at = -1;
        int busy_at = -1;
        bit both_gnt = 1'b0;
        @(negedge CLK);
        mem_rdata = 32'h0BADF00D;
        M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 26'h0000010;
        M1_REQ = 1'b1; M1_WE = 1'b1; M1_ADDR = 26'h0000020; M1_WDATA = 32'hAAAA5555;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 1'b0, 26'h0000010, '0, 32'h0BADF00D);
            push_exp(1'b1, 1'b1, 26'h0000020, 32'hAAAA5555, '0);
        end
        for (int cyc = 1; cyc <= 40 && ndone < 4; cyc++) begin
            @(negedge CLK);
            if (M0_GNT && M1_GNT) both_gnt = 1'b1;
            if (cyc == idle_at) begin
                checks++;
                if (BUSY !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_gap: busy=%b at cycle %0d, required 0", BUSY, cyc);
                end
            end
            if (cyc == busy_at) begin
                checks++;
                if (BUSY !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL regrant: busy=%b at cycle %0d, required 1", BUSY, cyc);
                end
            end
            if (M0_DONE || M1_DONE) begin
                order[ndone] = M1_DONE ? 1 : 0;
                ndone++;
                if (ndone < 4) begin
                    idle_at = cyc + 1;
                    busy_at = cyc + 2;
                end else begin
                    M0_REQ = 1'b0;
                    M1_REQ = 1'b0;
                end
            end
        end
        checks++;
        if (ndone != 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d accesses, required 4", ndone);
            M0_REQ = 1'b0;
            M1_REQ = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != (i % 2)) begin
                    errors++;
                    $display("[TB] FAIL b2b_order[%0d]: owner %0d, required %0d", i, order[i], i % 2);
                end
            end
        end
        checks++;
        if (both_gnt) begin
            errors++;
            $display("[TB] FAIL b2b_double_gnt: got 1, required 0");
        end
    endtask

    task automatic test_reset_mid_access();
        int m0_done_cnt = 0;
        bit m1_done = 1'b0;
        repeat (2) @(negedge CLK);
        M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 26'h0000055; mem_rdata = 32'h11112222;
        push_exp(1'b0, 1'b0, 26'h0000055, '0, 32'h11112222);
        @(negedge CLK);
        checks++;
        if (MEM_READ !== 1'b1 || M0_GNT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_setup: rd=%b gnt0=%b, required 1 1", MEM_READ, M0_GNT);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({MEM_READ, M0_GNT, BUSY} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL abort_immediate: rd/gnt/busy=%b, required 000", {MEM_READ, M0_GNT, BUSY});
        end
        sb.delete();
        model_rdata = '0;
        M1_REQ = 1'b1; M1_WE = 1'b1; M1_ADDR = 26'h0000066; M1_WDATA = 32'h0F0F0F0F;
        repeat (2) begin
            @(negedge CLK);
            if (M0_DONE) m0_done_cnt++;
        end
        checks++;
        if (m0_done_cnt != 0 || RDATA !== '0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: done=%0d rdata=%h, required 0 0", m0_done_cnt, RDATA);
        end
        push_exp(1'b0, 1'b0, 26'h0000055, '0, 32'h11112222);
        push_exp(1'b1, 1'b1, 26'h0000066, 32'h0F0F0F0F, '0);
        RST = 1'b1;
        @(negedge CLK);
        checks++;
        if ({M0_GNT, M1_GNT} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: gnt=%b, required 10", {M0_GNT, M1_GNT});
        end
        for (int cyc = 0; cyc < 20 && !m1_done; cyc++) begin
            @(negedge CLK);
            if (M0_DONE) M0_REQ = 1'b0;
            if (M1_DONE) begin
                M1_REQ = 1'b0;
                m1_done = 1'b1;
            end
        end
        checks++;
        if (!m1_done) begin
            errors++;
            $display("[TB] FAIL reset_followup: m1 done=0, required 1");
            M0_REQ = 1'b0;
            M1_REQ = 1'b0;
        end
    endtask

    task automatic test_withdrawn();
        int  done_cnt = 0;
        int  grants = 0;
        bit  prev_busy = 1'b1;
        logic [DW-1:0] rd_at_done = '0;
        repeat (2) @(negedge CLK);
        M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 26'h0000077; mem_rdata = 32'h77778888;
        push_exp(1'b0, 1'b0, 26'h0000077, '0, 32'h77778888);
        @(negedge CLK);
        checks++;
        if (M0_GNT !== 1'b1) begin
            errors++;
            $display("[TB] FAIL withdraw_gnt: gnt0=%b, required 1", M0_GNT);
        end
        M0_REQ = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge CLK);
            if (BUSY && !prev_busy) grants++;
            prev_busy = BUSY;
            if (M0_DONE) begin
                done_cnt++;
                rd_at_done = RDATA;
            end
        end
        checks++;
        if (done_cnt != 1 || grants != 0 || rd_at_done !== 32'h77778888) begin
            errors++;
            $display("[TB] FAIL withdraw: done=%0d regrants=%0d rdata=%h, required 1 0 77778888",
                     done_cnt, grants, rd_at_done);
        end
    endtask

    task automatic test_latency_one();
        int rd_cycles = 0;
        int done_cyc = -1;
        logic [DW-1:0] rd_at_done = '0;
        @(negedge CLK);
        l1_m0_req = 1'b1; l1_m0_we = 1'b0; l1_m0_addr = 26'h0000123; mem_rdata = 32'hCAFEF00D;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge CLK);
            if (l1_mem_read && l1_mem_addr === 26'h0000123) rd_cycles++;
            if (l1_m0_done) begin
                if (done_cyc < 0) done_cyc = cyc;
                rd_at_done = l1_rdata;
                l1_m0_req = 1'b0;
            end
        end
        checks++;
        if (rd_cycles != 1) begin
            errors++;
            $display("[TB] FAIL lat1_strobe: cycles=%0d, required 1", rd_cycles);
        end
        checks++;
        if (done_cyc != 2 || rd_at_done !== 32'hCAFEF00D) begin
            errors++;
            $display("[TB] FAIL lat1_done: cycle=%0d rdata=%h, required 2 cafef00d", done_cyc, rd_at_done);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_reset_mid_access();
        test_withdrawn();
        test_latency_one();
        repeat (4) @(negedge CLK);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not complete, required completion before 50000");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
